// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with first-word-fall-through read.
// A prefetch stage hides the registered read port so the head word sits on rd_data.
module sync_fifo_fwft #(
  parameter int unsigned DW     = 18,
  parameter int unsigned AW     = 7,
  parameter int unsigned AF_LVL = 2**AW - 2,
  parameter int unsigned AE_LVL = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  output logic          full,
  output logic          almost_full,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          almost_empty,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned Depth = 2**AW;
  localparam logic [AW:0] DepthC = (AW+1)'(Depth);
  localparam logic [AW:0] AfLvl  = (AW+1)'(AF_LVL);
  localparam logic [AW:0] AeLvl  = (AW+1)'(AE_LVL);
  localparam logic [AW:0] One    = (AW+1)'(1);

  logic [DW-1:0] mem_q [Depth];
  logic [DW-1:0] rd_data_q;

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [AW:0] ram_cnt;
  logic        rd_valid_q, rd_valid_d;
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;

  logic push, pop, prefetch;

  // Registered pointers only: a word written at this edge is never read at this edge.
  assign ram_cnt  = wr_ptr_q - rd_ptr_q;
  assign full     = (count_q == DepthC);
  assign push     = wr_en & ~full;
  assign pop      = rd_en & rd_valid_q;
  assign prefetch = (ram_cnt != '0) & (~rd_valid_q | pop);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_valid_d  = rd_valid_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      rd_valid_d  = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + One;
      end
      if (prefetch) begin
        rd_ptr_d   = rd_ptr_q + One;
        rd_valid_d = 1'b1;
      end else if (pop) begin
        rd_valid_d = 1'b0;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + One;
        2'b01:   count_d = count_q - One;
        default: count_d = count_q;
      endcase
      if (wr_en && full) begin
        overflow_d = 1'b1;
      end
      if (rd_en && !rd_valid_q) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage and its read-port register are intentionally not reset.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
    if (prefetch && !clr) begin
      rd_data_q <= mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign count        = count_q;
  assign almost_full  = (count_q >= AfLvl);
  assign almost_empty = (count_q <= AeLvl);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Bench for sync_fifo_fwft: queue-based reference model checked every cycle,
// plus directed literal expectations.
module tb_sync_fifo_fwft;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;
  localparam int unsigned Depth = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_en = 1'b0;
  logic          full, almost_full, rd_valid, almost_empty, overflow, underflow;
  logic [DW-1:0] rd_data;
  logic [AW:0]   count;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  sync_fifo_fwft #(
    .DW     (DW),
    .AW     (AW),
    .AF_LVL (2),
    .AE_LVL (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .almost_full  (almost_full),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  // Reference model: a word is visible at the head only once an edge has passed since its push.
  typedef struct {
    logic [DW-1:0] d;
    int unsigned   e;
  } ent_t;

  ent_t        mq[$];
  int unsigned edge_no = 0;
  bit          m_ov = 1'b0;
  bit          m_un = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_full;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
      m_valid = 1'b0;
      edge_no = 0;
    end else begin
      if (clr) begin
        mq.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
      end else begin
        m_full = (mq.size() == Depth);
        if (wr_en && m_full) m_ov = 1'b1;
        if (rd_en && !m_valid) m_un = 1'b1;
        if (rd_en && m_valid) void'(mq.pop_front());
        if (wr_en && !m_full) mq.push_back('{d: wr_data, e: edge_no});
      end
      m_valid = 1'b0;
      if (mq.size() > 0) begin
        if (mq[0].e < edge_no) m_valid = 1'b1;
      end
      edge_no++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("count", 32'(count), 32'(mq.size()));
      check("full", 32'(full), 32'(mq.size() == Depth));
      check("almost_full", 32'(almost_full), 32'(mq.size() >= 2));
      check("almost_empty", 32'(almost_empty), 32'(mq.size() <= 1));
      check("rd_valid", 32'(rd_valid), 32'(m_valid));
      check("overflow", 32'(overflow), 32'(m_ov));
      check("underflow", 32'(underflow), 32'(m_un));
      if (m_valid) check("rd_data", 32'(rd_data), 32'(mq[0].d));
    end
  end

  // Apply inputs for one edge, return at the following negedge.
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
    wr_en = w;
    wr_data = d;
    rd_en = r;
    clr = c;
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    check("rst_count", 32'(count), 0);
    check("rst_ae", 32'(almost_empty), 1);
    check("rst_valid", 32'(rd_valid), 0);

    // 1: first-word latency
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    check("t1_valid_e0", 32'(rd_valid), 0);
    check("t1_count_e0", 32'(count), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("t1_valid", 32'(rd_valid), 1);
    check("t1_data", 32'(rd_data), 32'hA5);
    check("t1_count", 32'(count), 1);
    check("t1_ae", 32'(almost_empty), 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t1_empty", 32'(rd_valid), 0);

    // 2: fill, overflow, streaming drain
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
    check("t2_full", 32'(full), 1);
    check("t2_count", 32'(count), 4);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    check("t2_ovf", 32'(overflow), 1);
    check("t2_count_ovf", 32'(count), 4);
    for (int i = 1; i <= 4; i++) begin
      check("t2_stream_valid", 32'(rd_valid), 1);
      check("t2_stream_data", 32'(rd_data), i);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("t2_drained_valid", 32'(rd_valid), 0);
    check("t2_drained_count", 32'(count), 0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("t2_ovf_clr", 32'(overflow), 0);

    // Full with pop: pop succeeds, push still rejected
    for (int i = 0; i < 4; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    check("full_pop_count", 32'(count), 3);
    check("full_pop_ovf", 32'(overflow), 1);
    check("full_pop_head", 32'(rd_data), 32'h21);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // 3: simultaneous push/pop at count=2
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    step(1'b1, 8'hBB, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'h10 + 8'(i), 1'b1, 1'b0);
      check("t3_count", 32'(count), 2);
    end
    check("t3_head", 32'(rd_data), 32'h11);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t3_head2", 32'(rd_data), 32'h12);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // 4: underflow is sticky until clr
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t4_unf", 32'(underflow), 1);
    check("t4_count", 32'(count), 0);
    check("t4_valid", 32'(rd_valid), 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("t4_unf_hold", 32'(underflow), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("t4_unf_clr", 32'(underflow), 0);

    // Push and pop together at count=1: pushed word becomes head one edge later
    step(1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h88, 1'b1, 1'b0);
    check("c1_count", 32'(count), 1);
    check("c1_valid", 32'(rd_valid), 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("c1_head", 32'(rd_data), 32'h88);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    // 5: random traffic, model checks every cycle
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(9) < 6), 8'($urandom), 1'($urandom_range(9) < 6), 1'b0);
    end
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // 6: asynchronous reset mid-cycle with count=3 and overflow set
    for (int i = 0; i < 4; i++) step(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t6_pre_count", 32'(count), 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_count", 32'(count), 0);
    check("t6_valid", 32'(rd_valid), 0);
    check("t6_full", 32'(full), 0);
    check("t6_af", 32'(almost_full), 0);
    check("t6_ae", 32'(almost_empty), 1);
    check("t6_ovf", 32'(overflow), 0);
    check("t6_unf", 32'(underflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    check("t6_first_valid", 32'(rd_valid), 1);
    check("t6_first_data", 32'(rd_data), 32'h5A);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check("t6_empty", 32'(count), 0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sync_fifo_fwft.md
Name: sync_fifo_fwft

Overview:
Parametrised single-clock FIFO with first-word-fall-through (show-ahead) read. It is built around an internal two-port storage array that has a registered read port. A prefetch controller hides the one-cycle read latency, so the head word is always presented on rd_data with rd_valid. The block adds occupancy count, programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. It is the generalised successor to the bare two-port RAM and serves as the standard buffering primitive in single-clock datapaths.

Parameters:
DW, 18, data width in bits
AW, 7, address width; DEPTH = 2**AW entries total capacity
AF_LVL, 2**AW-2, almost_full asserts when count >= AF_LVL; legal range 1..DEPTH
AE_LVL, 1, almost_empty asserts when count <= AE_LVL; legal range 0..DEPTH-1

Ports:
clk  input  1  single clock, all logic posedge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous flush, highest priority
wr_en  input  1  push request
wr_data  input  DW  push data
full  output  1  count == DEPTH
almost_full  output  1  count >= AF_LVL
rd_en  input  1  pop request (consumes head word when rd_valid=1)
rd_data  output  DW  head word; valid only when rd_valid=1
rd_valid  output  1  head word present (empty = !rd_valid)
almost_empty  output  1  count <= AE_LVL
count  output  AW+1  total entries held (array + head)
overflow  output  1  sticky: push attempted while full
underflow  output  1  sticky: pop attempted while !rd_valid

Behaviour:
- Storage: DEPTH x DW array. Write port and registered read port are both on clk. Storage is not reset. The read-port output register drives rd_data directly.
- Pointers: wr_ptr and rd_ptr, each AW+1 bits, wrap naturally. ram_cnt = wr_ptr - rd_ptr counts words not yet prefetched.
- push = wr_en & !full. On push: array[wr_ptr] <= wr_data, wr_ptr++.
- pop = rd_en & rd_valid.
- Prefetch fires when ram_cnt != 0 & (!rd_valid | pop). On prefetch: the read port captures array[rd_ptr], rd_ptr++, rd_valid <= 1.
- If pop fires without prefetch, rd_valid <= 0.
- ram_cnt uses registered pointers only. A word written at edge N is therefore never read at edge N, which removes the read-during-write hazard by construction.
- Latency: push into an empty FIFO at edge N gives rd_valid=1 and rd_data equal to that word after edge N+1. With rd_en held and the FIFO non-empty, one word is popped per cycle with no bubbles.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. It never exceeds DEPTH and never goes below 0.
- full, almost_full, almost_empty and rd_valid are decoded from registered state only. There is no combinational path from any input to any output.
- Full: wr_en is ignored (no pointer or data change) and overflow <= 1. A pop in the same cycle does not enable that push; the push is still rejected.
- Empty (rd_valid=0): rd_en is ignored and underflow <= 1.
- Simultaneous push and pop at count=1: the pop takes the head word, and the pushed word appears as head after the following edge.
- overflow and underflow hold until clr or reset.
- clr=1 at an edge: both pointers to 0, count 0, rd_valid 0, overflow/underflow 0. Any push or pop in that cycle is discarded. The array is not cleared.
- Reset (async assert, any time, including mid-burst): count=0, rd_valid=0, full=0, almost_full=0, almost_empty=1, overflow=0, underflow=0, pointers 0. rd_data is undefined until the first rd_valid.

Test Plan:
1. DW=8, AW=2. After reset, push 0xA5 at edge 0 -> rd_valid=1, rd_data=0xA5, count=1 after edge 1; almost_empty=1.
2. Push 0x01..0x04 back-to-back -> full=1 and count=4 after the 4th push. Push 0xFF while full -> ignored, overflow=1, count=4. Hold rd_en -> rd_data reads 01, 02, 03, 04 on consecutive cycles, then rd_valid=0 and count=0. 0xFF is never seen.
3. At count=2, assert wr_en and rd_en together for 3 cycles with data 0x10..0x12 -> count stays 2 and pop order matches a reference queue.
4. Empty FIFO, rd_en=1 -> underflow=1, count=0, rd_valid=0. Flags hold until clr, then clear after the clr edge.
5. Run 200 random push/pop cycles (about 60% busy) across multiple pointer wraps -> data order and count match a scoreboard. almost_full tracks count>=2 (AF_LVL=2) and almost_empty tracks count<=1 exactly.
6. At count=3, drop rst_n asynchronously mid-cycle -> all outputs take their reset values immediately, without waiting for a clock edge. After release, push 0x5A -> 0x5A is the first word popped.
